// File: rtl/gen_tm_multi_pkg.sv
// Shared definitions for the multi-channel interval generator.
// Mode encodings and the per-channel state type.
package gen_tm_multi_pkg;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } ch_state_e;

endpackage

// File: rtl/gen_tm_ch.sv
// One interval-generator channel: a ce-tick down-counter with a registered
// active level and a one-clock expiry pulse, optionally reloading periodically.
module gen_tm_ch
    import gen_tm_multi_pkg::*;
#(
    parameter int unsigned W      = 16,
    parameter int unsigned RETRIG = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         st,
    input  logic         stop,
    input  logic         mode,
    input  logic [W-1:0] len,
    output logic         tm,
    output logic         done
);

    ch_state_e    state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] len_q, len_d;
    logic         mode_q, mode_d;
    logic         done_q, done_d;
    logic         st_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
            mode_q  <= MODE_ONESHOT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // A zero-length start, or a start while running without retrigger, is treated as absent.
    assign st_ok = st && (len != '0) && ((state_q == StIdle) || (RETRIG != 0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (st_ok) begin
            state_d = StRun;
            cnt_d   = len;
            len_d   = len;
            mode_d  = mode;
        end else if (ce && (state_q == StRun)) begin
            if (cnt_q == W'(1)) begin
                done_d = 1'b1;
                if (mode_q == MODE_PERIODIC) begin
                    cnt_d = len_q;
                end else begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end else begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    always_comb begin
        tm   = (state_q == StRun);
        done = done_q;
    end

endmodule

// File: rtl/gen_tm_multi.sv
// Multi-channel interval generator: N_CH independent gen_tm_ch instances
// sharing clock, reset and clock enable.
module gen_tm_multi
    import gen_tm_multi_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned W      = 16,
    parameter int unsigned RETRIG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [N_CH-1:0]   st,
    input  logic [N_CH-1:0]   stop,
    input  logic [N_CH-1:0]   mode,
    input  logic [N_CH*W-1:0] len,
    output logic [N_CH-1:0]   Tm,
    output logic [N_CH-1:0]   done
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        gen_tm_ch #(
            .W      (W),
            .RETRIG (RETRIG)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .ce   (ce),
            .st   (st[i]),
            .stop (stop[i]),
            .mode (mode[i]),
            .len  (len[i*W +: W]),
            .tm   (Tm[i]),
            .done (done[i])
        );
    end

endmodule

// File: tb/tb_gen_tm_multi.sv
// Directed bench for gen_tm_multi: a retriggerable and a non-retriggerable
// instance driven from the same stimulus, checked against hand-computed values.
module tb_gen_tm_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [3:0]  st, stop, mode;
    logic [63:0] len_all;
    logic [3:0]  tm_a, done_a, tm_b, done_b;

    int n_vec = 0;
    int n_err = 0;

    gen_tm_multi #(.N_CH(4), .W(16), .RETRIG(1)) u_dut_rt (
        .clk (clk), .rst (rst), .ce (ce), .st (st), .stop (stop), .mode (mode),
        .len (len_all), .Tm (tm_a), .done (done_a)
    );

    gen_tm_multi #(.N_CH(4), .W(16), .RETRIG(0)) u_dut_nr (
        .clk (clk), .rst (rst), .ce (ce), .st (st), .stop (stop), .mode (mode),
        .len (len_all), .Tm (tm_b), .done (done_b)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [3:0]  stop;
        logic [15:0] len0;
        logic        ce;
        int          rep;
        logic [3:0]  etm;
        logic [3:0]  edone;
    } vec_t;

    vec_t vt[29];

    task automatic step(input logic [3:0] s, input logic [3:0] p, input logic [3:0] m,
                        input logic c);
        st   = s;
        stop = p;
        mode = m;
        ce   = c;
        @(posedge clk);
        #1;
        st   = '0;
        stop = '0;
        ce   = 1'b0;
    endtask

    task automatic chk2(input string nm, input logic [3:0] etm, input logic [3:0] edone,
                        input logic [3:0] etm_nr, input logic [3:0] edone_nr);
        n_vec += 2;
        if (tm_a !== etm || done_a !== edone) begin
            n_err++;
            $display("FAIL %s (retrig): Tm=%b done=%b, expected Tm=%b done=%b",
                     nm, tm_a, done_a, etm, edone);
        end
        if (tm_b !== etm_nr || done_b !== edone_nr) begin
            n_err++;
            $display("FAIL %s (no-retrig): Tm=%b done=%b, expected Tm=%b done=%b",
                     nm, tm_b, done_b, etm_nr, edone_nr);
        end
    endtask

    task automatic chk(input string nm, input logic [3:0] etm, input logic [3:0] edone);
        chk2(nm, etm, edone, etm, edone);
    endtask

    initial begin
        int tk;
        int cnt_a, cnt_b;
        int bad;
        logic [3:0] e_tm, e_dn, e_tm_b, e_dn_b;

        // ch0 one-shot, st coincident with ce, len=0 start, stop+st
        vt[0]  = '{4'h1, 4'h0, 16'd3, 1'b0, 1, 4'h1, 4'h0};
        vt[1]  = '{4'h0, 4'h0, 16'd3, 1'b0, 3, 4'h1, 4'h0};
        vt[2]  = '{4'h0, 4'h0, 16'd3, 1'b1, 1, 4'h1, 4'h0};
        vt[3]  = '{4'h0, 4'h0, 16'd3, 1'b0, 4, 4'h1, 4'h0};
        vt[4]  = '{4'h0, 4'h0, 16'd3, 1'b1, 1, 4'h1, 4'h0};
        vt[5]  = '{4'h0, 4'h0, 16'd3, 1'b0, 4, 4'h1, 4'h0};
        vt[6]  = '{4'h0, 4'h0, 16'd3, 1'b1, 1, 4'h0, 4'h1};
        vt[7]  = '{4'h0, 4'h0, 16'd3, 1'b0, 2, 4'h0, 4'h0};
        vt[8]  = '{4'h1, 4'h0, 16'd3, 1'b1, 1, 4'h1, 4'h0};
        vt[9]  = '{4'h0, 4'h0, 16'd3, 1'b0, 4, 4'h1, 4'h0};
        vt[10] = '{4'h0, 4'h0, 16'd3, 1'b1, 1, 4'h1, 4'h0};
        vt[11] = '{4'h0, 4'h0, 16'd3, 1'b0, 4, 4'h1, 4'h0};
        vt[12] = '{4'h0, 4'h0, 16'd3, 1'b1, 1, 4'h1, 4'h0};
        vt[13] = '{4'h0, 4'h0, 16'd3, 1'b0, 4, 4'h1, 4'h0};
        vt[14] = '{4'h0, 4'h0, 16'd3, 1'b1, 1, 4'h0, 4'h1};
        vt[15] = '{4'h0, 4'h0, 16'd3, 1'b0, 1, 4'h0, 4'h0};
        vt[16] = '{4'h1, 4'h0, 16'd0, 1'b0, 1, 4'h0, 4'h0};
        vt[17] = '{4'h0, 4'h0, 16'd0, 1'b1, 1, 4'h0, 4'h0};
        vt[18] = '{4'h1, 4'h1, 16'd3, 1'b0, 1, 4'h0, 4'h0};
        vt[19] = '{4'h0, 4'h0, 16'd3, 1'b0, 4, 4'h0, 4'h0};
        vt[20] = '{4'h0, 4'h0, 16'd3, 1'b1, 1, 4'h0, 4'h0};
        vt[21] = '{4'h1, 4'h0, 16'd3, 1'b0, 1, 4'h1, 4'h0};
        vt[22] = '{4'h1, 4'h1, 16'd3, 1'b0, 1, 4'h0, 4'h0};
        vt[23] = '{4'h0, 4'h0, 16'd3, 1'b1, 1, 4'h0, 4'h0};
        vt[24] = '{4'h0, 4'h0, 16'd3, 1'b0, 4, 4'h0, 4'h0};
        vt[25] = '{4'h1, 4'h0, 16'd2, 1'b0, 1, 4'h1, 4'h0};
        vt[26] = '{4'h0, 4'h0, 16'd2, 1'b1, 1, 4'h1, 4'h0};
        vt[27] = '{4'h1, 4'h0, 16'd0, 1'b0, 1, 4'h1, 4'h0};
        vt[28] = '{4'h0, 4'h0, 16'd0, 1'b1, 1, 4'h0, 4'h1};

        rst = 1'b1; ce = 1'b0; st = '0; stop = '0; mode = '0;
        len_all = {4{16'd5}};

        // Reset held with all starts asserted
        for (int k = 0; k < 3; k++) begin
            step(4'hF, 4'h0, 4'h0, k == 1);
            chk("reset_hold", 4'h0, 4'h0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step(4'h0, 4'h0, 4'h0, k == 5);
            chk("reset_release", 4'h0, 4'h0);
        end

        foreach (vt[i]) begin
            for (int r = 0; r < vt[i].rep; r++) begin
                len_all = {48'h0, vt[i].len0};
                step(vt[i].st, vt[i].stop, 4'h0, vt[i].ce);
                chk($sformatf("table_%0d", i), vt[i].etm, vt[i].edone);
            end
        end

        // Periodic ch1 len=2, then stop
        len_all = {16'd0, 16'd0, 16'd2, 16'd0};
        step(4'b0010, 4'h0, 4'b0010, 1'b0);
        chk("per_start", 4'b0010, 4'h0);
        tk = 0;
        for (int k = 1; k <= 20; k++) begin
            step(4'h0, 4'h0, 4'h0, (k % 5) == 0);
            if ((k % 5) == 0) tk++;
            e_dn = ((k % 5) == 0 && (tk % 2) == 0) ? 4'b0010 : 4'b0000;
            chk("per_run", 4'b0010, e_dn);
        end
        step(4'h0, 4'b0010, 4'h0, 1'b0);
        chk("per_stop", 4'h0, 4'h0);
        for (int k = 1; k <= 10; k++) begin
            step(4'h0, 4'h0, 4'h0, (k % 5) == 0);
            chk("per_after_stop", 4'h0, 4'h0);
        end

        // Stop coincident with an expiry tick: no done
        step(4'b0010, 4'h0, 4'b0010, 1'b0);
        chk("stopexp_start", 4'b0010, 4'h0);
        for (int k = 1; k <= 5; k++) begin
            step(4'h0, 4'h0, 4'h0, k == 5);
            chk("stopexp_tick1", 4'b0010, 4'h0);
        end
        for (int k = 1; k <= 4; k++) step(4'h0, 4'h0, 4'h0, 1'b0);
        step(4'h0, 4'b0010, 4'h0, 1'b1);
        chk("stopexp_stop", 4'h0, 4'h0);
        step(4'h0, 4'h0, 4'h0, 1'b0);
        chk("stopexp_after", 4'h0, 4'h0);

        // Retrigger ch2 len=4: second st after two ticks
        len_all = {16'd0, 16'd4, 16'd0, 16'd0};
        step(4'b0100, 4'h0, 4'h0, 1'b0);
        chk("retrig_st1", 4'b0100, 4'h0);
        for (int k = 1; k <= 10; k++) begin
            step(4'h0, 4'h0, 4'h0, (k % 5) == 0);
            chk("retrig_pre", 4'b0100, 4'h0);
        end
        step(4'b0100, 4'h0, 4'h0, 1'b0);
        chk("retrig_st2", 4'b0100, 4'h0);
        tk = 0; cnt_a = 0; cnt_b = 0;
        for (int k = 1; k <= 20; k++) begin
            step(4'h0, 4'h0, 4'h0, (k % 5) == 0);
            if ((k % 5) == 0) tk++;
            e_tm   = (tk < 4) ? 4'b0100 : 4'b0000;
            e_dn   = ((k % 5) == 0 && tk == 4) ? 4'b0100 : 4'b0000;
            e_tm_b = (tk < 2) ? 4'b0100 : 4'b0000;
            e_dn_b = ((k % 5) == 0 && tk == 2) ? 4'b0100 : 4'b0000;
            if (done_a[2]) cnt_a++;
            if (done_b[2]) cnt_b++;
            chk2("retrig_run", e_tm, e_dn, e_tm_b, e_dn_b);
        end
        n_vec++;
        if (cnt_a != 1 || cnt_b != 1) begin
            n_err++;
            $display("FAIL retrig_done_count: got %0d/%0d pulses, expected 1/1", cnt_a, cnt_b);
        end

        // st coincident with the expiry tick (ch2 len=2)
        len_all = {16'd0, 16'd2, 16'd0, 16'd0};
        step(4'b0100, 4'h0, 4'h0, 1'b0);
        chk("stexp_start", 4'b0100, 4'h0);
        for (int k = 1; k <= 5; k++) begin
            step(4'h0, 4'h0, 4'h0, k == 5);
            chk("stexp_tick1", 4'b0100, 4'h0);
        end
        for (int k = 1; k <= 4; k++) step(4'h0, 4'h0, 4'h0, 1'b0);
        step(4'b0100, 4'h0, 4'h0, 1'b1);
        chk2("stexp_coincide", 4'b0100, 4'h0, 4'h0, 4'b0100);
        for (int k = 1; k <= 10; k++) begin
            step(4'h0, 4'h0, 4'h0, (k % 5) == 0);
            e_tm = (k < 10) ? 4'b0100 : 4'b0000;
            e_dn = (k == 10) ? 4'b0100 : 4'b0000;
            chk2("stexp_reload", e_tm, e_dn, 4'h0, 4'h0);
        end

        // Independence: len = 1,2,3,4 started together
        len_all = {16'd4, 16'd3, 16'd2, 16'd1};
        step(4'hF, 4'h0, 4'h0, 1'b0);
        chk("indep_start", 4'hF, 4'h0);
        tk = 0;
        for (int k = 1; k <= 20; k++) begin
            step(4'h0, 4'h0, 4'h0, (k % 5) == 0);
            if ((k % 5) == 0) tk++;
            e_tm = 4'hF << tk;
            e_dn = ((k % 5) == 0) ? (4'b0001 << (tk - 1)) : 4'b0000;
            chk("indep", e_tm, e_dn);
        end

        // Maximum length on ch3 with ce every clock
        len_all = {16'hFFFF, 48'h0};
        step(4'b1000, 4'h0, 4'h0, 1'b0);
        chk("max_start", 4'b1000, 4'h0);
        bad = 0;
        for (int k = 1; k <= 65534; k++) begin
            step(4'h0, 4'h0, 4'h0, 1'b1);
            if (tm_a !== 4'b1000 || done_a !== 4'h0 || tm_b !== 4'b1000 || done_b !== 4'h0)
                bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL max_hold: %0d bad clocks during 65534 ticks, expected 0", bad);
        end
        chk("max_after_65534", 4'b1000, 4'h0);
        step(4'h0, 4'h0, 4'h0, 1'b1);
        chk("max_expiry", 4'h0, 4'b1000);
        step(4'h0, 4'h0, 4'h0, 1'b0);
        chk("max_after", 4'h0, 4'h0);

        // Reset mid-interval
        len_all = {48'h0, 16'd3};
        step(4'b0001, 4'h0, 4'h0, 1'b0);
        chk("rstmid_start", 4'b0001, 4'h0);
        for (int k = 1; k <= 5; k++) step(4'h0, 4'h0, 4'h0, k == 5);
        rst = 1'b1;
        step(4'h0, 4'h0, 4'h0, 1'b1);
        chk("rstmid_rst", 4'h0, 4'h0);
        rst = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step(4'h0, 4'h0, 4'h0, (k % 5) == 0);
            chk("rstmid_after", 4'h0, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
